// File: rtl/mac_rx_data_checker_if.sv
// Channel-to-checker bundle for the MAC receive data checker.
// The master side drives the received word stream; the slave side is the checker.
interface mac_rx_data_checker_if #(
   parameter int unsigned DWIDTH = 40
);
   localparam int unsigned W = DWIDTH * 2;

   logic          i_rx_transfer_en;
   logic          i_rx_align_done;
   logic [W-1:0]  i_data_out;
   logic          i_clr;
   logic          o_locked;
   logic [31:0]   o_word_cnt;
   logic [15:0]   o_err_cnt;
   logic          o_err_sticky;
   logic          o_loss_sticky;
   logic [W-1:0]  o_err_data;
   logic [W-1:0]  o_err_exp;

   modport master (
      output i_rx_transfer_en, i_rx_align_done, i_data_out, i_clr,
      input  o_locked, o_word_cnt, o_err_cnt, o_err_sticky, o_loss_sticky,
             o_err_data, o_err_exp
   );

   modport slave (
      input  i_rx_transfer_en, i_rx_align_done, i_data_out, i_clr,
      output o_locked, o_word_cnt, o_err_cnt, o_err_sticky, o_loss_sticky,
             o_err_data, o_err_exp
   );
endinterface

// File: rtl/mac_rx_data_checker.sv
// Receive-side pattern checker: locks onto a replicated 16-bit counter stream and counts errors.
// Optional first-error capture is built when MAC_CHK_ERR_LOG_EN is defined.
module mac_rx_data_checker #(
   parameter int unsigned DWIDTH      = 40,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned SEED_LANE_W = 16
) (
   input  logic                  m_rd_clk,
   input  logic                  rd_rstn,
   mac_rx_data_checker_if.slave  bus
);
   localparam int unsigned W      = DWIDTH * 2;
   localparam int unsigned IDX_W  = $clog2(W);
   localparam int unsigned LANE_W = $clog2(SEED_LANE_W);
   localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {IDLE, SEEK, LOCK} state_t;

   state_t                  state_q, state_d;
   logic [SEED_LANE_W-1:0]  exp_q, exp_d;
   logic [MISS_W-1:0]       miss_q, miss_d;
   logic                    locked_q;
   logic [31:0]             word_cnt_q;
   logic [15:0]             err_cnt_q;
   logic                    err_sticky_q;
   logic                    loss_sticky_q;

   logic                    link_c;
   logic                    consistent_c;
   logic                    compare_c;
   logic                    mismatch_c;
   logic                    loss_c;
   logic [W-1:0]            exp_word_c;

   // Lane value replicated from bit 0 upward, top lane truncated
   function automatic logic [W-1:0] pattern(input logic [SEED_LANE_W-1:0] c);
      logic [W-1:0] p;
      p = '0;
      for (int i = 0; i < int'(W); i++)
         p[IDX_W'(i)] = c[LANE_W'(i % int'(SEED_LANE_W))];
      return p;
   endfunction

   // Next-state, expected-value and miss-counter logic
   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      miss_d       = miss_q;
      compare_c    = 1'b0;
      mismatch_c   = 1'b0;
      loss_c       = 1'b0;
      link_c       = bus.i_rx_transfer_en & bus.i_rx_align_done;
      exp_word_c   = pattern(exp_q);
      consistent_c = (bus.i_data_out == pattern(bus.i_data_out[SEED_LANE_W-1:0]));

      case (state_q)
         IDLE: begin
            if (link_c) state_d = SEEK;
         end
         SEEK: begin
            if (!link_c) begin
               state_d = IDLE;
            end else if (consistent_c) begin
               state_d = LOCK;
               exp_d   = bus.i_data_out[SEED_LANE_W-1:0] + SEED_LANE_W'(1);
               miss_d  = '0;
            end
         end
         LOCK: begin
            if (!link_c) begin
               state_d = IDLE;
            end else begin
               compare_c  = 1'b1;
               mismatch_c = (bus.i_data_out != exp_word_c);
               exp_d      = exp_q + SEED_LANE_W'(1);
               // A clear discards this cycle's compare, including its effect on lock
               if (bus.i_clr) begin
                  miss_d = '0;
               end else if (mismatch_c) begin
                  if (miss_q == MISS_W'(LOSS_THRESH - 1)) begin
                     loss_c  = 1'b1;
                     miss_d  = '0;
                     state_d = SEEK;
                  end else begin
                     miss_d = miss_q + MISS_W'(1);
                  end
               end else begin
                  miss_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         miss_q   <= miss_d;
         locked_q <= (state_d == LOCK);
      end
   end

   // Saturating statistics and sticky flags
   always_ff @(posedge m_rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         word_cnt_q    <= '0;
         err_cnt_q     <= '0;
         err_sticky_q  <= 1'b0;
         loss_sticky_q <= 1'b0;
      end else if (bus.i_clr) begin
         word_cnt_q    <= '0;
         err_cnt_q     <= '0;
         err_sticky_q  <= 1'b0;
         loss_sticky_q <= 1'b0;
      end else if (compare_c) begin
         if (word_cnt_q != '1) word_cnt_q <= word_cnt_q + 32'd1;
         if (mismatch_c) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
            err_sticky_q <= 1'b1;
         end
         if (loss_c) loss_sticky_q <= 1'b1;
      end
   end

`ifdef MAC_CHK_ERR_LOG_EN
   logic          captured_q;
   logic [W-1:0]  err_data_q;
   logic [W-1:0]  err_exp_q;

   // Hold the first failing word until reset or clear
   always_ff @(posedge m_rd_clk or negedge rd_rstn) begin
      if (!rd_rstn) begin
         captured_q <= 1'b0;
         err_data_q <= '0;
         err_exp_q  <= '0;
      end else if (bus.i_clr) begin
         captured_q <= 1'b0;
         err_data_q <= '0;
         err_exp_q  <= '0;
      end else if (compare_c && mismatch_c && !captured_q) begin
         captured_q <= 1'b1;
         err_data_q <= bus.i_data_out;
         err_exp_q  <= exp_word_c;
      end
   end

   assign bus.o_err_data = err_data_q;
   assign bus.o_err_exp  = err_exp_q;
`else
   assign bus.o_err_data = '0;
   assign bus.o_err_exp  = '0;
`endif

   assign bus.o_locked      = locked_q;
   assign bus.o_word_cnt    = word_cnt_q;
   assign bus.o_err_cnt     = err_cnt_q;
   assign bus.o_err_sticky  = err_sticky_q;
   assign bus.o_loss_sticky = loss_sticky_q;
endmodule

// File: tb/tb_mac_rx_data_checker.sv
// Scoreboard bench for mac_rx_data_checker: directed scenarios plus a random stream
// checked against a behavioural model of the lock/compare rules.
module tb_mac_rx_data_checker;
   localparam int unsigned DWIDTH      = 40;
   localparam int unsigned W           = DWIDTH * 2;
   localparam int unsigned LOSS_THRESH = 4;
   localparam int M_IDLE = 0, M_SEEK = 1, M_LOCK = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mac_rx_data_checker_if #(.DWIDTH(DWIDTH)) bus ();

   mac_rx_data_checker #(.DWIDTH(DWIDTH), .LOSS_THRESH(LOSS_THRESH)) dut (
      .m_rd_clk (clk),
      .rd_rstn  (rst_n),
      .bus      (bus)
   );

   typedef struct packed {
      logic          locked;
      logic [31:0]   wc;
      logic [15:0]   ec;
      logic          es;
      logic          ls;
      logic [W-1:0]  ed;
      logic [W-1:0]  ee;
   } obs_t;

   obs_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   int           m_st;
   logic [15:0]  m_exp;
   int           m_miss;
   logic [31:0]  m_wc;
   logic [15:0]  m_ec;
   logic         m_es, m_ls, m_cap;
   logic [W-1:0] m_ed, m_ee;
   logic [15:0]  c;

   function automatic logic [W-1:0] pat(input logic [15:0] v);
      logic [(W/16+1)*16-1:0] r;
      r = {(W/16+1){v}};
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_exp = '0; m_miss = 0;
      m_wc = '0; m_ec = '0; m_es = 1'b0; m_ls = 1'b0; m_cap = 1'b0;
      m_ed = '0; m_ee = '0;
   endtask

   // Apply one cycle of inputs, advance the model, queue the expected outputs
   task automatic drive(input logic en, input logic al, input logic [W-1:0] d, input logic clr);
      bit link, cmp, mis, lost;
      logic [W-1:0] want;
      obs_t o;
      bus.i_rx_transfer_en = en;
      bus.i_rx_align_done  = al;
      bus.i_data_out       = d;
      bus.i_clr            = clr;
      @(posedge clk);
      #1;
      link = en && al;
      want = pat(m_exp);
      cmp  = (m_st == M_LOCK) && link;
      mis  = cmp && (d != want);
      lost = 1'b0;
      if (!link) m_st = M_IDLE;
      else if (m_st == M_IDLE) m_st = M_SEEK;
      else if (m_st == M_SEEK) begin
         if (d == pat(d[15:0])) begin
            m_st = M_LOCK; m_exp = d[15:0] + 16'd1; m_miss = 0;
         end
      end else begin
         m_exp = m_exp + 16'd1;
         if (clr) m_miss = 0;
         else if (mis) begin
            m_miss++;
            if (m_miss == LOSS_THRESH) begin
               m_st = M_SEEK; m_miss = 0; lost = 1'b1;
            end
         end else m_miss = 0;
      end
      if (clr) begin
         m_wc = '0; m_ec = '0; m_es = 1'b0; m_ls = 1'b0; m_cap = 1'b0; m_ed = '0; m_ee = '0;
      end else if (cmp) begin
         if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 32'd1;
         if (mis) begin
            if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
            m_es = 1'b1;
            if (!m_cap) begin m_cap = 1'b1; m_ed = d; m_ee = want; end
         end
         if (lost) m_ls = 1'b1;
      end
      o.locked = (m_st == M_LOCK);
      o.wc = m_wc; o.ec = m_ec; o.es = m_es; o.ls = m_ls;
`ifdef MAC_CHK_ERR_LOG_EN
      o.ed = m_ed; o.ee = m_ee;
`else
      o.ed = '0; o.ee = '0;
`endif
      exp_q.push_back(o);
   endtask

   task automatic send(input logic [15:0] v);
      drive(1'b1, 1'b1, pat(v), 1'b0);
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Scoreboard monitor: compare every presented output set against the queue
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.o_locked, bus.o_word_cnt, bus.o_err_cnt, bus.o_err_sticky,
                 bus.o_loss_sticky, bus.o_err_data, bus.o_err_exp};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL scoreboard t=%0t locked %b/%b wc %0d/%0d ec %0d/%0d es %b/%b ls %b/%b ed %h/%h ee %h/%h",
                        $time, a.locked, e.locked, a.wc, e.wc, a.ec, e.ec, a.es, e.es,
                        a.ls, e.ls, a.ed, e.ed, a.ee, e.ee);
            end
         end
      end
   end

   initial begin
      int r;
      logic [W-1:0] w;
      rst_n = 1'b0;
      bus.i_rx_transfer_en = 1'b0;
      bus.i_rx_align_done  = 1'b0;
      bus.i_data_out       = '0;
      bus.i_clr            = 1'b0;
      model_reset();
      #12;
      chk("rst_locked", W'(bus.o_locked), '0);
      chk("rst_word_cnt", W'(bus.o_word_cnt), '0);
      chk("rst_err_cnt", W'(bus.o_err_cnt), '0);
      chk("rst_stickies", W'({bus.o_err_sticky, bus.o_loss_sticky}), '0);
      chk("rst_err_log", bus.o_err_data | bus.o_err_exp, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Lock and run on c = 0x0010..0x010F
      drive(1'b1, 1'b1, rnd_word(), 1'b0);
      for (int k = 0; k < 256; k++) begin
         c = 16'h0010 + 16'(k);
         send(c);
         if (k == 0) chk("lock_latency", W'(bus.o_locked), W'(1));
      end
      chk("run_locked", W'(bus.o_locked), W'(1));
      chk("run_word_cnt", W'(bus.o_word_cnt), W'(255));
      chk("run_err_cnt", W'(bus.o_err_cnt), '0);

      // Counter wrap across 0xFFFF -> 0x0000
      drive(1'b0, 1'b1, rnd_word(), 1'b0);
      chk("drop_to_idle", W'(bus.o_locked), '0);
      drive(1'b1, 1'b1, rnd_word(), 1'b1);
      for (int k = 0; k < 7; k++) begin
         c = 16'hFFFC + 16'(k);
         send(c);
      end
      chk("wrap_err_cnt", W'(bus.o_err_cnt), '0);
      chk("wrap_word_cnt", W'(bus.o_word_cnt), W'(6));

      // Single error on c = 0x0005
      send(16'h0003);
      send(16'h0004);
      w = pat(16'h0005) ^ W'(8);
      drive(1'b1, 1'b1, w, 1'b0);
      for (int k = 6; k < 10; k++) send(16'(k));
      chk("single_err_cnt", W'(bus.o_err_cnt), W'(1));
      chk("single_err_sticky", W'(bus.o_err_sticky), W'(1));
      chk("single_lock_held", W'(bus.o_locked), W'(1));
`ifdef MAC_CHK_ERR_LOG_EN
      chk("single_err_exp", bus.o_err_exp, pat(16'h0005));
      chk("single_err_data", bus.o_err_data, w);
`else
      chk("err_log_absent", bus.o_err_data | bus.o_err_exp, '0);
`endif

      // Loss of lock after consecutive corrupt words, then relock
      drive(1'b1, 1'b1, pat(16'h000A), 1'b1);
      for (int k = 11; k < 15; k++) drive(1'b1, 1'b1, pat(16'(k)) ^ W'(8), 1'b0);
      chk("loss_sticky", W'(bus.o_loss_sticky), W'(1));
      chk("loss_unlocked", W'(bus.o_locked), '0);
      for (int k = 0; k < 5; k++) send(16'h0100 + 16'(k));
      chk("relock", W'(bus.o_locked), W'(1));
      chk("relock_err_cnt", W'(bus.o_err_cnt), W'(4));

      // Transfer drop mid-stream, counters held, then relock
      drive(1'b0, 1'b1, pat(16'h0105), 1'b0);
      chk("xfer_drop_unlocked", W'(bus.o_locked), '0);
      chk("xfer_drop_word_cnt", W'(bus.o_word_cnt), W'(8));
      drive(1'b1, 1'b1, pat(16'h0106), 1'b0);
      for (int k = 0; k < 4; k++) send(16'h2000 + 16'(k));
      chk("xfer_relock", W'(bus.o_locked), W'(1));
      chk("xfer_word_cnt", W'(bus.o_word_cnt), W'(11));

      // Clear coincident with a mismatch
      drive(1'b1, 1'b1, pat(16'h2004) ^ W'(8), 1'b1);
      chk("clr_counts", W'({bus.o_word_cnt, bus.o_err_cnt}), '0);
      chk("clr_stickies", W'({bus.o_err_sticky, bus.o_loss_sticky}), '0);
      chk("clr_lock_held", W'(bus.o_locked), W'(1));
      send(16'h2005);
      chk("clr_expected_kept", W'({bus.o_word_cnt, bus.o_err_cnt}), W'({32'd1, 16'd0}));

      // Random stream
      c = 16'(16'h2006);
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 80) begin
            send(c); c = c + 16'd1;
         end else if (r < 88) begin
            w = pat(c) ^ (W'(1) << $urandom_range(0, W - 1));
            drive(1'b1, 1'b1, w, 1'b0); c = c + 16'd1;
         end else if (r < 92) begin
            drive(1'b1, 1'b1, rnd_word(), 1'b0); c = c + 16'd1;
         end else if (r < 95) begin
            if ($urandom_range(0, 1) == 0) drive(1'b0, 1'b1, pat(c), 1'b0);
            else drive(1'b1, 1'b0, pat(c), 1'b0);
            c = c + 16'd1;
         end else if (r < 97) begin
            drive(1'b1, 1'b1, pat(c), 1'b1); c = c + 16'd1;
         end else begin
            c = c + 16'd2;
         end
      end

      // Asynchronous reset while locked
      drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b1, 1'b1, rnd_word(), 1'b0);
      for (int k = 0; k < 4; k++) send(16'h4000 + 16'(k));
      chk("pre_reset_locked", W'(bus.o_locked), W'(1));
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_locked", W'(bus.o_locked), '0);
      chk("async_rst_counts", W'({bus.o_word_cnt, bus.o_err_cnt}), '0);
      chk("async_rst_stickies", W'({bus.o_err_sticky, bus.o_loss_sticky}), '0);
      chk("async_rst_err_log", bus.o_err_data | bus.o_err_exp, '0);
      model_reset();
      exp_q.delete();
      rst_n = 1'b1;
      drive(1'b1, 1'b1, rnd_word(), 1'b0);
      send(16'h5000);
      send(16'h5001);
      chk("post_reset_word_cnt", W'(bus.o_word_cnt), W'(1));

      @(negedge clk);
      #1;
      chk("scoreboard_drained", W'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
